// File: rtl/ibex_pkg.sv
// Shared RV32 encoding types: base opcodes, encoder operations, funct codes and immediate bounds.
// Latency: none (types, constants and pure field-packing functions only).
// Backpressure: not applicable.
package ibex_pkg;

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0f,
        OPCODE_OP_IMM   = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_OP       = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6f,
        OPCODE_SYSTEM   = 7'h73
    } opcode_e;

    typedef enum logic [3:0] {
        ENC_ADD,
        ENC_SUB,
        ENC_AND,
        ENC_OR,
        ENC_XOR,
        ENC_ADDI,
        ENC_LB,
        ENC_LH,
        ENC_LW,
        ENC_SB,
        ENC_SH,
        ENC_SW,
        ENC_MUL,
        ENC_DIV,
        ENC_LUI,
        ENC_JAL
    } enc_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_BYTE    = 3'b000;
    localparam logic [2:0] F3_HALF    = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam int signed IMM12_MIN   = -2048;
    localparam int signed IMM12_MAX   = 2047;
    localparam int signed JAL_IMM_MIN = -(1 << 20);
    localparam int signed JAL_IMM_MAX = (1 << 20) - 2;

    // One FIFO entry: the err flag rides alongside the (zeroed) word.
    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } enc_word_t;

    function automatic logic [31:0] enc_r(input logic [6:0] funct7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] funct3,
                                          input logic [4:0] rd);
        return {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] funct3, input logic [4:0] rd,
                                          input opcode_e opcode);
        return {imm, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] funct3);
        return {imm[11:5], rs2, rs1, funct3, imm[4:0], OPCODE_STORE};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm_hi, input logic [4:0] rd);
        return {imm_hi, rd, OPCODE_LUI};
    endfunction

    // imm_j holds imm[20:1]; bit 0 of a jump offset is never encoded.
    function automatic logic [31:0] enc_j(input logic [19:0] imm_j, input logic [4:0] rd);
        return {imm_j[19], imm_j[9:0], imm_j[10], imm_j[18:11], rd, OPCODE_JAL};
    endfunction

endpackage

// File: rtl/ibex_encoder_fifo.sv
// Generic power-of-two synchronous FIFO with registered state and zeroed head when empty.
// Latency: a push at edge N is visible at the head after edge N; no write-to-read bypass.
// Backpressure: pushes are ignored while full and pops while empty; no same-cycle full bypass.
module ibex_encoder_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AW-1:0] PtrOne   = AW'(1);
    localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
    localparam logic [AW:0]   DepthCnt = (AW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DepthCnt);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_data = empty ? '0 : mem[rptr];

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PtrOne;
            end
            if (do_pop) begin
                rptr <= rptr + PtrOne;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntOne;
                2'b01:   count <= count - CntOne;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_instr_encoder.sv
// Streams symbolic RV32 requests into encoded words via a Depth-entry FIFO; MUL/DIV need IBEX_ENC_RV32M_EN.
// Latency: a word accepted at edge N is at the output head after edge N; no request-to-output comb path.
// Backpressure: req_ready_o is low while the FIFO is full and during/just out of reset.
module ibex_instr_encoder
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  enc_op_e     req_op_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic [15:0] instr_cnt_o
);

    logic signed [31:0] imm_s;
    logic               imm12_ok;
    logic               jal_ok;
    logic               lui_ok;
    logic [31:0]        enc_word;
    logic               enc_err;
    enc_word_t          push_entry;
    enc_word_t          head_entry;
    logic               ready_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [15:0]        cnt;

    assign imm_s    = req_imm_i;
    assign imm12_ok = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
    assign jal_ok   = !req_imm_i[0] && (imm_s >= JAL_IMM_MIN) && (imm_s <= JAL_IMM_MAX);
    assign lui_ok   = (req_imm_i[11:0] == 12'h000);

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (req_op_i)
            ENC_ADD: enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, F3_ADD_SUB, req_rd_i);
            ENC_SUB: enc_word = enc_r(F7_SUB,  req_rs2_i, req_rs1_i, F3_ADD_SUB, req_rd_i);
            ENC_AND: enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, F3_AND, req_rd_i);
            ENC_OR:  enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, F3_OR, req_rd_i);
            ENC_XOR: enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, F3_XOR, req_rd_i);
            ENC_ADDI: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_i(req_imm_i[11:0], req_rs1_i, F3_ADD_SUB, req_rd_i, OPCODE_OP_IMM);
            end
            ENC_LB: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_i(req_imm_i[11:0], req_rs1_i, F3_BYTE, req_rd_i, OPCODE_LOAD);
            end
            ENC_LH: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_i(req_imm_i[11:0], req_rs1_i, F3_HALF, req_rd_i, OPCODE_LOAD);
            end
            ENC_LW: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_i(req_imm_i[11:0], req_rs1_i, F3_WORD, req_rd_i, OPCODE_LOAD);
            end
            ENC_SB: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_s(req_imm_i[11:0], req_rs2_i, req_rs1_i, F3_BYTE);
            end
            ENC_SH: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_s(req_imm_i[11:0], req_rs2_i, req_rs1_i, F3_HALF);
            end
            ENC_SW: begin
                enc_err  = ~imm12_ok;
                enc_word = enc_s(req_imm_i[11:0], req_rs2_i, req_rs1_i, F3_WORD);
            end
`ifdef IBEX_ENC_RV32M_EN
            ENC_MUL: enc_word = enc_r(F7_MULDIV, req_rs2_i, req_rs1_i, F3_MUL, req_rd_i);
            ENC_DIV: enc_word = enc_r(F7_MULDIV, req_rs2_i, req_rs1_i, F3_DIV, req_rd_i);
`else
            ENC_MUL: enc_err = 1'b1;
            ENC_DIV: enc_err = 1'b1;
`endif
            ENC_LUI: begin
                enc_err  = ~lui_ok;
                enc_word = enc_u(req_imm_i[31:12], req_rd_i);
            end
            ENC_JAL: begin
                enc_err  = ~jal_ok;
                enc_word = enc_j(req_imm_i[20:1], req_rd_i);
            end
            default: enc_err = 1'b1;
        endcase
        // Unencodable requests still occupy a slot so ordering is preserved.
        if (enc_err) begin
            enc_word = '0;
        end
    end

    assign push_entry = '{err: enc_err, word: enc_word};

    // Holds off acceptance until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign req_ready_o   = ready_en & ~fifo_full;
    assign push          = req_valid_i & req_ready_o;
    assign instr_valid_o = ~fifo_empty;
    assign pop           = instr_valid_o & instr_ready_i;

    ibex_encoder_fifo #(
        .Depth (Depth),
        .Width ($bits(enc_word_t))
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_rdata_o = head_entry.word;
    assign instr_err_o   = head_entry.err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign instr_cnt_o = cnt;

endmodule
